serial_fir_mac: RTL and testbench

Parametrised successor of the serial-in/FIR/serial-out datapath, built as one self-contained block. It accepts samples over a LANES-bit-wide serial stream and filters them with a time-multiplexed, single-multiplier direct-form FIR whose coefficients are runtime-loadable. It rounds and saturates each result and streams it back out LANES bits per beat, MSB- or LSB-first. It sits between the serial I/O pins and downstream serial consumers, replacing the fixed deserializer/FIR/serializer chain.

---
 rtl/serial_fir_mac_if.sv | 43 ++++
 rtl/serial_fir_mac.sv | 142 ++++++++++++++
 tb/tb_serial_fir_mac.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_fir_mac_if.sv
// rtl/serial_fir_mac_if.sv - stream, coefficient and status bundle for serial_fir_mac
// Purpose: groups every handshake/bus signal of serial_fir_mac so it travels as one port.
// Ports (master = surrounding logic, slave = serial_fir_mac):
//   i_en          master->slave  global enable
//   iv_din        master->slave  LANES-bit serial input beat
//   i_din_valid   master->slave  input beat valid
//   o_ready       slave->master  input beat can be accepted
//   i_coef_we     master->slave  coefficient write strobe
//   iv_coef_addr  master->slave  coefficient index
//   iv_coef_data  master->slave  signed coefficient value
//   i_ready       master->slave  downstream accepts an output beat
//   ov_dout       slave->master  LANES-bit serial output beat
//   o_dout_valid  slave->master  output beat valid
//   o_busy        slave->master  filter is computing
interface serial_fir_mac_if #(
  parameter int COEF_WIDTH = 18,
  parameter int TAPS       = 16,
  parameter int LANES      = 1
);
  localparam int AW = $clog2(TAPS);

  logic                  i_en;
  logic [LANES-1:0]      iv_din;
  logic                  i_din_valid;
  logic                  o_ready;
  logic                  i_coef_we;
  logic [AW-1:0]         iv_coef_addr;
  logic [COEF_WIDTH-1:0] iv_coef_data;
  logic                  i_ready;
  logic [LANES-1:0]      ov_dout;
  logic                  o_dout_valid;
  logic                  o_busy;

  modport master (
    output i_en, iv_din, i_din_valid, i_coef_we, iv_coef_addr, iv_coef_data, i_ready,
    input  o_ready, ov_dout, o_dout_valid, o_busy
  );

  modport slave (
    input  i_en, iv_din, i_din_valid, i_coef_we, iv_coef_addr, iv_coef_data, i_ready,
    output o_ready, ov_dout, o_dout_valid, o_busy
  );
endinterface

// File: rtl/serial_fir_mac.sv
// rtl/serial_fir_mac.sv - serial-in, single-multiplier FIR, rounded/saturated serial-out
// Purpose: deserialises LANES-bit beats into DATA_WIDTH samples, runs a TAPS-long direct-form
//   FIR one MAC per cycle with runtime-loadable coefficients, rounds by SHIFT, saturates and
//   reserialises the result.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      serial_fir_mac_if slave: enable, input stream, coefficient port, output stream, busy
module serial_fir_mac #(
  parameter int DATA_WIDTH = 24,
  parameter int COEF_WIDTH = 18,
  parameter int TAPS       = 16,
  parameter int LANES      = 1,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int SHIFT      = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  serial_fir_mac_if.slave bus
);
  localparam int BEATS     = DATA_WIDTH / LANES;
  localparam int AW        = $clog2(TAPS);
  localparam int ACC_WIDTH = DATA_WIDTH + COEF_WIDTH + AW;
  localparam int PW        = DATA_WIDTH + COEF_WIDTH;
  localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [AW-1:0] LAST_TAP  = AW'(TAPS - 1);
  localparam logic signed [ACC_WIDTH:0] RND_BIAS = (ACC_WIDTH + 1)'(1) << (SHIFT - 1);

  typedef enum logic [1:0] {S_COLLECT, S_MAC, S_ROUND, S_SHIFT_OUT} state_t;
  state_t state, state_nxt;

  logic [BW-1:0]                beat_cnt;
  logic [AW-1:0]                k, wp, rd_idx;
  logic [DATA_WIDTH-1:0]        asm_q, asm_nxt, osr, y_sat;
  logic signed [DATA_WIDTH-1:0] hist [TAPS];
  logic signed [COEF_WIDTH-1:0] coef [TAPS];
  logic signed [ACC_WIDTH-1:0]  acc, prod_ext;
  logic signed [PW-1:0]         prod;
  logic signed [ACC_WIDTH:0]    rnd_sum, y;
  logic [DATA_WIDTH+LANES-1:0]  cat_msb, cat_lsb;
  logic in_fire, out_fire, last_beat, y_fits;

  assign in_fire   = bus.i_en && bus.i_din_valid && (state == S_COLLECT);
  assign out_fire  = bus.i_en && bus.i_ready && (state == S_SHIFT_OUT);
  assign last_beat = (beat_cnt == LAST_BEAT);

  // New beat enters at the LSB end (MSB-first) or the MSB end (LSB-first).
  assign cat_msb = {asm_q, bus.iv_din};
  assign cat_lsb = {bus.iv_din, asm_q};
  assign asm_nxt = MSB_FIRST ? cat_msb[DATA_WIDTH-1:0] : cat_lsb[DATA_WIDTH+LANES-1:LANES];

  // Newest sample lives at wp, so tap k reads wp-k; AW-bit arithmetic wraps modulo TAPS.
  assign rd_idx   = wp - k;
  assign prod     = coef[k] * hist[rd_idx];
  assign prod_ext = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};

  // One guard bit above the accumulator so the rounding bias can never wrap.
  assign rnd_sum = {acc[ACC_WIDTH-1], acc} + RND_BIAS;
  assign y       = rnd_sum >>> SHIFT;
  assign y_fits  = (&y[ACC_WIDTH:DATA_WIDTH-1]) || !(|y[ACC_WIDTH:DATA_WIDTH-1]);
  assign y_sat   = y_fits ? y[DATA_WIDTH-1:0]
                 : (y[ACC_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_COLLECT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.i_en) begin
      case (state)
        S_COLLECT:   if (in_fire && last_beat) state_nxt = S_MAC;
        S_MAC:       if (k == LAST_TAP) state_nxt = S_ROUND;
        S_ROUND:     state_nxt = S_SHIFT_OUT;
        S_SHIFT_OUT: if (out_fire && last_beat) state_nxt = S_COLLECT;
        default:     state_nxt = S_COLLECT;
      endcase
    end
  end

  always_comb begin
    bus.o_ready      = 1'b0;
    bus.o_busy       = 1'b0;
    bus.o_dout_valid = 1'b0;
    bus.ov_dout      = '0;
    case (state)
      S_COLLECT: bus.o_ready = 1'b1;
      S_MAC, S_ROUND: bus.o_busy = 1'b1;
      S_SHIFT_OUT: begin
        bus.o_dout_valid = 1'b1;
        bus.ov_dout      = MSB_FIRST ? osr[DATA_WIDTH-1 -: LANES] : osr[LANES-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat_cnt <= '0;
      k        <= '0;
      wp       <= '0;
      asm_q    <= '0;
      osr      <= '0;
      acc      <= '0;
      for (int i = 0; i < TAPS; i++) begin
        hist[i] <= '0;
        coef[i] <= '0;
      end
    end else if (bus.i_en) begin
      // Coefficients are frozen only while they are being consumed.
      if (bus.i_coef_we && state != S_MAC) coef[bus.iv_coef_addr] <= bus.iv_coef_data;
      case (state)
        S_COLLECT: if (in_fire) begin
          asm_q <= asm_nxt;
          if (last_beat) begin
            hist[wp] <= asm_nxt;
            acc      <= '0;
            k        <= '0;
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt + BW'(1);
          end
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          k   <= k + AW'(1);
        end
        S_ROUND: begin
          osr <= y_sat;
          wp  <= wp + AW'(1);
        end
        S_SHIFT_OUT: if (out_fire) begin
          osr      <= MSB_FIRST ? (osr << LANES) : (osr >> LANES);
          beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_fir_mac.sv
// tb/tb_serial_fir_mac.sv - scoreboard bench for serial_fir_mac, LSB-first and MSB-first in lockstep
module tb_serial_fir_mac;
  localparam int DW = 24, CW = 18, TAPS = 4, LANES = 4, SHIFT = 16;
  localparam int BEATS = DW / LANES, AW = $clog2(TAPS);
  localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (DW - 1));

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic en, din_valid, coef_we, dready, rand_mode;
  logic [LANES-1:0] din_a, din_b;
  logic [AW-1:0] caddr;
  logic [CW-1:0] cdata;

  serial_fir_mac_if #(.COEF_WIDTH(CW), .TAPS(TAPS), .LANES(LANES)) if_a ();
  serial_fir_mac_if #(.COEF_WIDTH(CW), .TAPS(TAPS), .LANES(LANES)) if_b ();

  assign if_a.i_en = en;          assign if_b.i_en = en;
  assign if_a.iv_din = din_a;     assign if_b.iv_din = din_b;
  assign if_a.i_din_valid = din_valid;  assign if_b.i_din_valid = din_valid;
  assign if_a.i_coef_we = coef_we;      assign if_b.i_coef_we = coef_we;
  assign if_a.iv_coef_addr = caddr;     assign if_b.iv_coef_addr = caddr;
  assign if_a.iv_coef_data = cdata;     assign if_b.iv_coef_data = cdata;
  assign if_a.i_ready = dready;   assign if_b.i_ready = dready;

  serial_fir_mac #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .TAPS(TAPS), .LANES(LANES),
                   .MSB_FIRST(1'b0), .SHIFT(SHIFT))
    dut_lsb (.i_clk(clk), .i_rst_n(rst_n), .bus(if_a));
  serial_fir_mac #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .TAPS(TAPS), .LANES(LANES),
                   .MSB_FIRST(1'b1), .SHIFT(SHIFT))
    dut_msb (.i_clk(clk), .i_rst_n(rst_n), .bus(if_b));

  int total = 0, bad = 0;
  longint hist_q[$];
  longint mcoef[TAPS];
  logic [DW-1:0] sb_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: y[n] = sat(round(sum_k c[k]*x[n-k] / 2^SHIFT)), x before the first sample is 0.
  function automatic logic [DW-1:0] model_y();
    longint acc = 0;
    for (int j = 0; j < TAPS; j++)
      if (j < hist_q.size()) acc += mcoef[j] * hist_q[j];
    acc = (acc + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    if (acc > MAXV) acc = MAXV;
    else if (acc < MINV) acc = MINV;
    return acc[DW-1:0];
  endfunction

  function automatic logic [LANES-1:0] beat_of(input logic [DW-1:0] w, input int j, input bit msb);
    int base = msb ? (DW - LANES - j * LANES) : j * LANES;
    return w[base +: LANES];
  endfunction

  task automatic send_word(input logic [DW-1:0] w, input bit with_wr = 1'b0,
                           input logic [AW-1:0] wa = '0, input logic [CW-1:0] wd = '0);
    bit got;
    for (int j = 0; j < BEATS; j++) begin
      if (rand_mode) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      din_a = beat_of(w, j, 1'b0);
      din_b = beat_of(w, j, 1'b1);
      din_valid = 1'b1;
      if (with_wr && j == BEATS - 1) begin coef_we = 1'b1; caddr = wa; cdata = wd; end
      got = 1'b0;
      for (int c = 0; c < 500 && !got; c++) begin
        @(negedge clk);
        if (if_a.o_ready && en) got = 1'b1;
        @(posedge clk); #1;
      end
      din_valid = 1'b0;
      coef_we = 1'b0;
      if (!got) begin
        total++; bad++;
        $display("FAIL send_timeout: beat %0d not accepted, required within 500 cycles", j);
        return;
      end
    end
    if (with_wr) mcoef[wa] = longint'($signed(wd));
    hist_q.push_front(longint'($signed(w)));
    if (hist_q.size() > TAPS) void'(hist_q.pop_back());
    sb_q.push_back(model_y());
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [CW-1:0] d);
    bit got = 1'b0;
    caddr = a; cdata = d; coef_we = 1'b1;
    for (int c = 0; c < 500 && !got; c++) begin
      @(negedge clk);
      if (en && !if_a.o_busy) got = 1'b1;
      @(posedge clk); #1;
    end
    coef_we = 1'b0;
    mcoef[a] = longint'($signed(d));
  endtask

  task automatic wait_valid();
    bit got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (if_a.o_dout_valid) got = 1'b1;
    end
    check("wait_valid_timeout", got, 1);
    @(posedge clk); #1;
  endtask

  // Counts cycles from the first MAC cycle until output valid; optional 3-cycle enable drop in MAC.
  task automatic measure_latency(input bit pulse, output int lat);
    lat = -1;
    for (int c = 1; c <= 64 && lat < 0; c++) begin
      if (pulse) en = !(c >= 2 && c <= 4);
      @(negedge clk);
      if (if_a.o_dout_valid) lat = c;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    en = 1'b1;
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (rand_mode) begin
      en = ($urandom_range(0, 7) != 0);
      dready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: collects output beats of both instances and checks them against the scoreboard.
  int nb = 0;
  bit pv = 1'b0;
  logic [LANES-1:0] pda, pdb;
  logic [DW-1:0] wa_acc, wb_acc, exp_w;
  always @(negedge clk) begin
    if (!rst_n) begin
      nb = 0; pv = 1'b0;
    end else begin
      if (!if_a.o_dout_valid) begin
        check("idle_dout_lsb", if_a.ov_dout, 0);
        check("idle_dout_msb", if_b.ov_dout, 0);
      end
      if (pv) begin
        check("hold_valid", if_a.o_dout_valid, 1);
        check("hold_dout_lsb", if_a.ov_dout, pda);
        check("hold_dout_msb", if_b.ov_dout, pdb);
      end
      pv = if_a.o_dout_valid && !(dready && en);
      pda = if_a.ov_dout;
      pdb = if_b.ov_dout;
      if (if_a.o_dout_valid && dready && en) begin
        wa_acc[nb * LANES +: LANES] = if_a.ov_dout;
        wb_acc[DW - LANES - nb * LANES +: LANES] = if_b.ov_dout;
        nb++;
        if (nb == BEATS) begin
          nb = 0;
          if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_word: got 0x%0h with no sample outstanding", wa_acc);
          end else begin
            exp_w = sb_q.pop_front();
            check("word_lsb_first", wa_acc, exp_w);
            check("word_msb_first", wb_acc, exp_w);
          end
        end
      end
    end
  end

  initial begin
    int lat;
    en = 1'b1; din_valid = 1'b0; coef_we = 1'b0; dready = 1'b1; rand_mode = 1'b0;
    din_a = '0; din_b = '0; caddr = '0; cdata = '0;
    for (int j = 0; j < TAPS; j++) mcoef[j] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", if_a.o_ready, 1);
    check("reset_valid", if_a.o_dout_valid, 0);
    check("reset_dout", if_a.ov_dout, 0);
    check("reset_busy", if_a.o_busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int j = 0; j < TAPS; j++) write_coef(AW'(j), CW'(65536));
    send_word(DW'(100));
    repeat (4) send_word('0);
    repeat (4) send_word(24'h7FFFFF);
    repeat (4) send_word(24'h800000);

    write_coef('0, CW'(32768));
    for (int j = 1; j < TAPS; j++) write_coef(AW'(j), '0);
    send_word(DW'(3));
    send_word(DW'(-3));

    write_coef('0, CW'(65536));
    send_word(24'hABCDEF);
    send_word(24'h000100, 1'b1, '0, CW'(-65536));
    write_coef('0, CW'(65536));

    send_word(DW'(1000));
    coef_we = 1'b1; caddr = '0; cdata = CW'(12345);
    @(posedge clk); #1;
    coef_we = 1'b0;
    send_word(DW'(7));

    send_word(DW'(50));
    measure_latency(1'b0, lat);
    check("latency", lat, TAPS + 2);
    send_word(DW'(60));
    measure_latency(1'b1, lat);
    check("latency_en_pulse", lat, TAPS + 5);

    send_word(24'h123456);
    wait_valid();
    @(posedge clk); #1;
    dready = 1'b0;
    repeat (5) @(posedge clk);
    #1 dready = 1'b1;

    for (int j = 0; j < TAPS; j++) write_coef(AW'(j), CW'(65536));
    send_word(DW'(5000));
    wait_valid();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", if_a.o_dout_valid, 0);
    check("midrst_ready", if_a.o_ready, 1);
    check("midrst_busy", if_a.o_busy, 0);
    sb_q.delete();
    hist_q.delete();
    for (int j = 0; j < TAPS; j++) mcoef[j] = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int j = 0; j < TAPS; j++) write_coef(AW'(j), CW'(65536));
    send_word(DW'(100));

    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) write_coef(AW'($urandom_range(0, TAPS - 1)), CW'($urandom));
      send_word(DW'($urandom));
    end
    rand_mode = 1'b0;
    @(posedge clk); #1;
    en = 1'b1; dready = 1'b1;
    for (int c = 0; c < 2000 && (sb_q.size() != 0 || nb != 0); c++) @(posedge clk);
    #1;
    check("drain_outstanding", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
